lane_scatter: RTL

- Writer-side front end for the combinational reduction tree.
- Accepts a serial stream of W-bit operands on a valid/ready interface and packs them into an N-lane unpacked vector sized to feed the tree's data_in[N] port directly.
- Presents each completed vector with a lane count on a second valid/ready interface; unfilled lanes are zero, so they contribute nothing to the sum.

---
 rtl/lane_scatter_pkg.sv | 15 +
 rtl/lane_scatter_if.sv | 48 ++++
 rtl/lane_scatter.sv | 109 ++++++++++
 3 files changed

// File: rtl/lane_scatter_pkg.sv
// Shared types and helpers for the lane scatter front end.
package scatter_pkg;

    // FILL: collecting beats into lanes; HOLD: presenting a completed vector.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } scatter_state_t;

    // Width needed to hold a count in the range 0..n.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lane_scatter_if.sv
// Bundles the operand stream (in_*) and the lane-vector stream (out_*).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until the
// transfer, and valid never depends combinationally on ready.
interface lane_scatter_if
    import scatter_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = clog2p1(N)
) ();

    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;

    logic [W-1:0]  out_data [N];
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;

    // The scatter block itself: consumes operands, produces vectors.
    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output out_data,
        output out_count,
        output out_valid,
        input  out_ready
    );

    // Operand producer and vector consumer side.
    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  out_data,
        input  out_count,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/lane_scatter.sv
// Packs a serial W-bit operand stream into N-lane vectors for the reduction
// tree. Unfilled lanes are zero so they add nothing to the downstream sum.
// A vector in HOLD can be handed off in the same cycle the next vector's
// first beat arrives, so the stream runs without bubbles.
module lane_scatter
    import scatter_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = clog2p1(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    lane_scatter_if.slave  bus,
    output scatter_state_t dbg_state
);

    scatter_state_t state;
    logic [W-1:0]   lanes [N];
    logic [CW-1:0]  idx;
    logic [CW-1:0]  count;
    // Held low through reset so in_ready only rises after the first edge.
    logic           armed;

    logic           beat_acc;
    logic           beat_closes;
    logic [CW-1:0]  wr_idx;

    // in_ready depends only on registered state and the consumer's ready.
    assign bus.in_ready = armed & ((state == FILL) | bus.out_ready);
    assign beat_acc     = bus.in_valid & bus.in_ready;

    // In HOLD an accepted beat always starts a fresh vector at lane 0.
    assign wr_idx      = (state == HOLD) ? '0 : idx;
    assign beat_closes = bus.in_last | (wr_idx == CW'(N - 1));

    assign bus.out_valid = (state == HOLD);
    assign bus.out_count = count;
    assign bus.out_data  = lanes;
    assign dbg_state     = state;

    // Lane array, index counter and FILL/HOLD state machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
            idx   <= '0;
            count <= '0;
            armed <= 1'b0;
            for (int i = 0; i < N; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            case (state)
                FILL: begin
                    if (beat_acc) begin
                        for (int i = 0; i < N; i++) begin
                            if (wr_idx == CW'(i)) begin
                                lanes[i] <= bus.in_data;
                            end
                        end
                        if (beat_closes) begin
                            state <= HOLD;
                            count <= wr_idx + CW'(1);
                            idx   <= '0;
                        end else begin
                            idx <= wr_idx + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // A beat can only be accepted here when the vector is taken.
                    if (bus.out_ready) begin
                        for (int i = 0; i < N; i++) begin
                            lanes[i] <= '0;
                        end
                        if (beat_acc) begin
                            lanes[0] <= bus.in_data;
                            if (beat_closes) begin
                                state <= HOLD;
                                count <= CW'(1);
                                idx   <= '0;
                            end else begin
                                state <= FILL;
                                count <= '0;
                                idx   <= CW'(1);
                            end
                        end else begin
                            state <= FILL;
                            count <= '0;
                            idx   <= '0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    count <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Simulation-only guard against a degenerate lane count.
    always_ff @(posedge clk) begin
        assert (N >= 1) else $fatal(1, "lane_scatter: N must be at least 1");
    end

endmodule
